// File: rtl/input_conditioner.sv
// Button conditioning for the game controller: synchronize, debounce, edge-detect,
// and arbitrate turn requests. Define INPUT_SYNC_EN to include the two-flop synchronizers.
module input_conditioner #(
   parameter int DEBOUNCE_TICKS = 3,
   parameter int HOLD_TICKS     = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_start,
   input  logic       raw_lturn,
   input  logic       raw_rturn,
   input  logic       raw_uturn,
   input  logic       consume,
   input  logic       pause,
   output logic       start_pulse,
   output logic       turn_valid,
   output logic [1:0] turn_req
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   localparam int B_START = 0;
   localparam int B_LTURN = 1;
   localparam int B_RTURN = 2;
   localparam int B_UTURN = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   logic [3:0] raw_vec;
   logic [3:0] sync_lvl;

   assign raw_vec = {raw_uturn, raw_rturn, raw_lturn, raw_start};

`ifdef INPUT_SYNC_EN
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_vec;
         sync2_q <= sync1_q;
      end
   end

   assign sync_lvl = sync2_q;
`else
   assign sync_lvl = raw_vec;
`endif

   logic [3:0]    level_q;
   logic [3:0]    level_d;
   logic [3:0]    level_dly_q;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [3:0]    rise;

   // A level flips only after DEBOUNCE_TICKS consecutive cycles of disagreement.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync_lvl[i] != level_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               level_d[i] = sync_lvl[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q     <= '0;
         level_dly_q <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         level_q     <= level_d;
         level_dly_q <= level_q;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rise = level_q & ~level_dly_q;

   logic start_pulse_q;
   logic start_pulse_d;

   assign start_pulse_d = rise[B_START];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_pulse_q <= 1'b0;
      end else begin
         start_pulse_q <= start_pulse_d;
      end
   end

   assign start_pulse = start_pulse_q;

   logic       accept;
   logic [1:0] new_dir;

   // U-turn wins outright; left and right together cancel each other.
   always_comb begin
      accept  = 1'b0;
      new_dir = 2'b00;
      if (rise[B_UTURN]) begin
         accept  = 1'b1;
         new_dir = 2'b11;
      end else if (rise[B_LTURN] && !rise[B_RTURN]) begin
         accept  = 1'b1;
         new_dir = 2'b01;
      end else if (rise[B_RTURN] && !rise[B_LTURN]) begin
         accept  = 1'b1;
         new_dir = 2'b10;
      end
   end

   state_t        state_q;
   state_t        state_d;
   logic [1:0]    dir_q;
   logic [1:0]    dir_d;
   logic [HW-1:0] hold_q;
   logic [HW-1:0] hold_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= 2'b00;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
      end
   end

   // A fresh edge always takes priority over consume and expiry (newest wins).
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = PENDING;
               dir_d   = new_dir;
               hold_d  = HOLD_LOAD;
            end
         end
         PENDING: begin
            if (accept) begin
               dir_d  = new_dir;
               hold_d = HOLD_LOAD;
            end else if (consume) begin
               state_d = IDLE;
               dir_d   = 2'b00;
               hold_d  = '0;
            end else if (!pause) begin
               if (hold_q == HOLD_ONE) begin
                  state_d = IDLE;
                  dir_d   = 2'b00;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q - HOLD_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            dir_d   = 2'b00;
            hold_d  = '0;
         end
      endcase
   end

   assign turn_valid = (state_q == PENDING);
   assign turn_req   = turn_valid ? dir_q : 2'b00;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed testbench for input_conditioner at default parameters; expected
// latencies adapt to whether INPUT_SYNC_EN is defined.
module tb_input_conditioner;

`ifdef INPUT_SYNC_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif
   localparam int H = 30;

   logic       clk = 1'b0;
   logic       rst;
   logic       raw_start;
   logic       raw_lturn;
   logic       raw_rturn;
   logic       raw_uturn;
   logic       consume;
   logic       pause;
   logic       start_pulse;
   logic       turn_valid;
   logic [1:0] turn_req;

   int compared   = 0;
   int mismatched = 0;

   input_conditioner dut (
      .clk         (clk),
      .rst         (rst),
      .raw_start   (raw_start),
      .raw_lturn   (raw_lturn),
      .raw_rturn   (raw_rturn),
      .raw_uturn   (raw_uturn),
      .consume     (consume),
      .pause       (pause),
      .start_pulse (start_pulse),
      .turn_valid  (turn_valid),
      .turn_req    (turn_req)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic l, input logic r, input logic u);
      raw_start = s;
      raw_lturn = l;
      raw_rturn = r;
      raw_uturn = u;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int pulses;
   int first_pulse;
   int stray_valid;

   initial begin
      rst     = 1'b1;
      consume = 1'b0;
      pause   = 1'b0;
      applyStimulus(0, 0, 0, 0);
      waitCycles(2);
      checkOutput("rst_start_pulse", start_pulse, 0);
      checkOutput("rst_turn_valid", turn_valid, 0);
      checkOutput("rst_turn_req", turn_req, 0);
      rst = 1'b0;
      waitCycles(3);
      checkOutput("post_rst_valid", turn_valid, 0);

      // left press: valid after LAT edges, lasts exactly H cycles while held
      applyStimulus(0, 1, 0, 0);
      waitCycles(LAT);
      checkOutput("left_early", turn_valid, 0);
      waitCycles(1);
      checkOutput("left_valid", turn_valid, 1);
      checkOutput("left_req", turn_req, 2'b01);
      waitCycles(H - 1);
      checkOutput("left_hold_last", turn_valid, 1);
      waitCycles(1);
      checkOutput("left_expired", turn_valid, 0);
      checkOutput("left_expired_req", turn_req, 0);
      waitCycles(5);
      checkOutput("left_held_no_repeat", turn_valid, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // two-cycle glitch must be rejected
      stray_valid = 0;
      applyStimulus(0, 0, 1, 0);
      waitCycles(2);
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (turn_valid !== 1'b0) stray_valid++;
      end
      checkOutput("glitch_rejected", stray_valid, 0);

      // start held 10 cycles gives one pulse
      pulses      = 0;
      first_pulse = -1;
      applyStimulus(1, 0, 0, 0);
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (start_pulse === 1'b1) begin
            pulses++;
            if (first_pulse < 0) first_pulse = i;
         end
         if (i == 10) applyStimulus(0, 0, 0, 0);
      end
      checkOutput("start_count", pulses, 1);
      checkOutput("start_latency", first_pulse, LAT + 1);
      checkOutput("start_no_turn", turn_valid, 0);
      waitCycles(6);

      // left then right: newest wins and hold restarts
      applyStimulus(0, 1, 0, 0);
      waitCycles(LAT + 1);
      checkOutput("lr_left_req", turn_req, 2'b01);
      applyStimulus(0, 0, 1, 0);
      waitCycles(LAT);
      checkOutput("lr_still_left", turn_req, 2'b01);
      waitCycles(1);
      checkOutput("lr_right_req", turn_req, 2'b10);
      waitCycles(H - 1);
      checkOutput("lr_restart_hold", turn_valid, 1);
      waitCycles(1);
      checkOutput("lr_expired", turn_valid, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // left and right together is a conflict
      applyStimulus(0, 1, 1, 0);
      waitCycles(LAT + 3);
      checkOutput("conflict_ignored", turn_valid, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // U-turn beats left, then consume clears
      applyStimulus(0, 1, 0, 1);
      waitCycles(LAT + 1);
      checkOutput("uturn_valid", turn_valid, 1);
      checkOutput("uturn_req", turn_req, 2'b11);
      applyStimulus(0, 0, 0, 0);
      consume = 1'b1;
      waitCycles(1);
      consume = 1'b0;
      checkOutput("consume_clears", turn_valid, 0);
      checkOutput("consume_req", turn_req, 0);
      waitCycles(10);

      // consume coinciding with a new left edge keeps the request
      applyStimulus(0, 0, 1, 0);
      waitCycles(LAT + 1);
      checkOutput("cc_right_req", turn_req, 2'b10);
      applyStimulus(0, 1, 0, 0);
      waitCycles(LAT);
      consume = 1'b1;
      waitCycles(1);
      consume = 1'b0;
      checkOutput("cc_valid", turn_valid, 1);
      checkOutput("cc_req", turn_req, 2'b01);
      consume = 1'b1;
      waitCycles(1);
      consume = 1'b0;
      checkOutput("cc_second_consume", turn_valid, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // pause 20 cycles mid-hold stretches validity to 50 cycles
      applyStimulus(0, 1, 0, 0);
      waitCycles(LAT + 1);
      checkOutput("pause_start", turn_valid, 1);
      waitCycles(10);
      pause = 1'b1;
      waitCycles(20);
      pause = 1'b0;
      checkOutput("pause_still_valid", turn_valid, 1);
      waitCycles(19);
      checkOutput("pause_last", turn_valid, 1);
      waitCycles(1);
      checkOutput("pause_expired", turn_valid, 0);
      applyStimulus(0, 0, 0, 0);
      waitCycles(10);

      // asynchronous reset mid-request, then button held through release
      applyStimulus(0, 1, 0, 0);
      waitCycles(LAT + 1);
      checkOutput("arst_before", turn_valid, 1);
      rst = 1'b1;
      #1;
      checkOutput("arst_valid", turn_valid, 0);
      checkOutput("arst_req", turn_req, 0);
      checkOutput("arst_pulse", start_pulse, 0);
      waitCycles(1);
      rst = 1'b0;
      waitCycles(LAT);
      checkOutput("held_early", turn_valid, 0);
      waitCycles(1);
      checkOutput("held_fresh_valid", turn_valid, 1);
      checkOutput("held_fresh_req", turn_req, 2'b01);
      applyStimulus(0, 0, 0, 0);
      waitCycles(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the raw controller button levels (NES or bongo, after the top-level `ctrl_select` mux) before they reach `game_controller`. It synchronizes and debounces them, then turns edges into a one-cycle start pulse and a buffered turn request. The request is held until game logic consumes it at a tile centre or it expires. The block runs on the game clock, between the controller mux and the game controller.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, default 3: consecutive cycles of disagreement needed before a debounced level changes; legal range ≥1.
- `HOLD_TICKS`, default 30: number of unpaused cycles a turn request stays valid if it is not consumed; legal range ≥1.

Ports:
- `clk`  in  1  game clock (60 Hz tick).
- `rst`  in  1  asynchronous, active-high reset.
- `raw_start`  in  1  raw start button level.
- `raw_lturn`  in  1  raw left-turn level.
- `raw_rturn`  in  1  raw right-turn level.
- `raw_uturn`  in  1  raw U-turn level.
- `consume`  in  1  game logic has applied the pending turn this cycle.
- `pause`  in  1  freezes the hold timer.
- `start_pulse`  out  1  registered, one cycle wide, on a debounced start rising edge.
- `turn_valid`  out  1  a turn request is pending.
- `turn_req`  out  2  pending direction: 00 none, 01 left, 10 right, 11 U-turn; reads 00 whenever `turn_valid`=0.

## Operation
Input path, per button:
- Two-flop synchronizer, reset to 0.
- Debounce counter of width clog2(DEBOUNCE_TICKS+1).
  - The counter increments on each edge where the synchronized value differs from the debounced level, and clears on agreement.
  - The debounced level flips on the edge where the counter would reach DEBOUNCE_TICKS; the counter clears on that same edge.
- Rising edge is `db & ~db_q`, where `db_q` is a one-cycle delayed copy of the debounced level.

Start path:
- `start_pulse` is a register that loads the start rising edge.
- It is independent of the request FSM and of `pause`.

Request FSM, states IDLE and PENDING, plus a hold counter:
- Edge arbitration within one cycle:
  - U-turn beats left and right.
  - Left and right together, without U-turn, is a conflict and is ignored.
- IDLE:
  - An accepted edge captures the direction, loads the counter with HOLD_TICKS, and moves to PENDING.
- PENDING:
  - An accepted edge replaces the direction and reloads the counter (newest wins).
  - Otherwise, `consume` moves to IDLE.
  - Otherwise, if `pause`=0, the counter decrements; a decrement from 1 moves to IDLE.
  - If `pause`=1, the counter holds.
- `consume` and an accepted edge in the same cycle: the new direction is captured, the state stays PENDING, and the counter is reloaded.
- `consume` while IDLE is ignored.
- Holding a button produces only one request; a new request needs a release and re-press through debounce.
- Edges that arrive during `pause` are still captured.

## Timing
- Reset: all synchronizer flops, debounced levels, counters and `db_q` go to 0; the FSM goes to IDLE.
- Outputs during and immediately after reset: `start_pulse`=0, `turn_valid`=0, `turn_req`=00.
- Asserting `rst` mid-request drops the request immediately (asynchronous).
- A button held through reset release is seen as a fresh press after the normal latency.
- Latency with `INPUT_SYNC_EN` defined:
  - Raw level stable before edge N.
  - Debounced level flips at edge N+1+DEBOUNCE_TICKS.
  - `turn_valid` / `start_pulse` go high after edge N+2+DEBOUNCE_TICKS, which is edge N+5 at defaults.
- Without `INPUT_SYNC_EN`, the same path is 2 cycles shorter: N+DEBOUNCE_TICKS.
- With no pause and no consume, `turn_valid` stays high for exactly HOLD_TICKS cycles.
- `consume` at edge M: `turn_valid` reads 0 after edge M.
- Glitches shorter than DEBOUNCE_TICKS cycles produce no output.

## Configuration
- `INPUT_SYNC_EN` defined: the two-flop synchronizers are present. This is required when the raw inputs come from the NES or GameCube clock domains.
- `INPUT_SYNC_EN` undefined: raw inputs feed the debouncers directly. Total latency drops by 2 cycles; all other behaviour is unchanged.

## Test plan
All scenarios use defaults and `INPUT_SYNC_EN` defined.
- Reset check: `raw_lturn` rises before edge 10, `rst` released earlier → `turn_valid`=1 and `turn_req`=01 after edge 15; `turn_valid` falls after edge 45 (30 cycles).
- Glitch rejection: `raw_rturn` high for 2 cycles → no request. Press `raw_start` for 10 cycles → exactly one `start_pulse`, 5 cycles after the press.
- Left then right: left pending, then `raw_rturn` pressed → `turn_req` becomes 10 and the hold counter restarts at 30. Left and right pressed in the same cycle → no request. U-turn and left pressed in the same cycle → `turn_req`=11.
- Consume: pending request plus `consume` → `turn_valid`=0 next cycle. `consume` coinciding with a new left edge → `turn_valid` stays 1 with `turn_req`=01.
- Pause: request pending, `pause` high for 20 cycles mid-hold → total valid time is 50 cycles. `rst` pulse mid-request → all outputs 0 immediately.
- Sync variant: rebuild without `INPUT_SYNC_EN`, raw stable before edge N → `turn_valid` high after edge N+3.
